adder_32b_seq: RTL

Word-serial multi-word adder that sits directly upstream of, and wraps, the existing combinational `adder_32b`. It accepts two `WORDS*32`-bit operands streamed one 32-bit word per beat, least-significant word first, on a valid/ready input. Each word pair passes through `adder_32b` with the carry registered between beats. Sum words are emitted on a registered valid/ready output, with the final carry and signed overflow flagged on the last word.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_32b.sv | 22 ++
 rtl/adder_32b_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared widths and control-state encoding for the word-serial
//                multi-word adder (adder_32b_seq).
//                  WORD_W  - width of one streamed operand word
//                  IDX_W   - width of the word index carried with each sum word
//                  state_e - IDLE (awaiting word 0) / BUSY (mid-operand)
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int WORD_W = 32;
    localparam int IDX_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_32b.sv
`default_nettype none
// ============================================================================
//  Module      : adder_32b
//  Description : Existing combinational 32-bit ripple adder with carry in/out.
//  Ports       : a, b      - 32-bit addends
//                carry_in  - carry into bit 0
//                sum       - 32-bit sum
//                carry_out - carry out of bit 31
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carry_in};

endmodule : adder_32b
`default_nettype wire

// File: rtl/adder_32b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : adder_32b_seq
//  Description : Word-serial multi-word adder. Two WORDS*32-bit operands are
//                streamed LS word first, one word pair per beat, through a
//                single adder_32b with the carry registered between beats.
//                Sum words leave through a single-entry registered output
//                stage; the last word carries the final carry and the signed
//                overflow of the full-width add.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid/in_ready     - input word-pair handshake
//                in_a, in_b            - operand words
//                in_carry_in           - operand carry-in (word 0 only)
//                out_valid/out_ready   - output handshake
//                out_sum, out_idx      - sum word and its index
//                out_last              - sum word is word WORDS-1
//                out_carry, out_ovf    - final carry / overflow (last word only)
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_32b_seq
    import adder_pkg::*;
#(
    parameter int WORDS = 4     // words per operand, 1..256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_carry,
    output logic              out_ovf
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic                carry_q,     carry_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_sum_q,   out_sum_d;
    logic [IDX_W-1:0]    out_idx_q,   out_idx_d;
    logic                out_last_q,  out_last_d;
    logic                out_carry_q, out_carry_d;
    logic                out_ovf_q,   out_ovf_d;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic              w_xfer;
    logic              w_first;
    logic              w_last;
    logic              w_add_cin;
    logic [WORD_W-1:0] w_add_sum;
    logic              w_add_cout;
    logic              w_ovf;

    // Output slot frees up in the same cycle the consumer takes it, so a
    // full-rate stream never bubbles.
    assign in_ready = !out_valid_q || out_ready;
    assign w_xfer   = in_valid && in_ready;

    // IDLE is exactly "next word is word 0"; with WORDS == 1 the block never
    // leaves IDLE so every beat takes the external carry-in.
    assign w_first   = (state_q == IDLE);
    assign w_last    = (idx_q == LAST_IDX);
    assign w_add_cin = w_first ? in_carry_in : carry_q;

    adder_32b u_adder (
        .a         (in_a),
        .b         (in_b),
        .carry_in  (w_add_cin),
        .sum       (w_add_sum),
        .carry_out (w_add_cout)
    );

    // Overflow of the full-width add depends only on the MS word's sign bits.
    assign w_ovf = w_last
                && (in_a[WORD_W-1] == in_b[WORD_W-1])
                && (w_add_sum[WORD_W-1] != in_a[WORD_W-1]);

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;

        if (w_xfer) begin
            idx_d       = w_last ? '0 : idx_q + 1'b1;
            state_d     = w_last ? IDLE : BUSY;
            carry_d     = w_add_cout;
            out_valid_d = 1'b1;
            out_sum_d   = w_add_sum;
            out_idx_d   = idx_q;
            out_last_d  = w_last;
            out_carry_d = w_last && w_add_cout;
            out_ovf_d   = w_ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;

endmodule : adder_32b_seq
`default_nettype wire
